// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the pipeline, the store buffer and data memory.
//   XLEN        - architectural address/data width
//   WORD_OFF_W  - number of byte-offset bits below the word address
//   st_req_t    - layout of a store request {word address, data}
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int WORD_OFF_W = 2;

    typedef logic [XLEN-1:WORD_OFF_W] word_addr_t;

    typedef struct packed {
        word_addr_t        waddr;
        logic [XLEN-1:0]   data;
    } st_req_t;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: combinational store-to-load forwarding matcher.
// Scans the buffered entries youngest-first and returns the data of the
// youngest valid entry whose word address equals the probe word address.
//   valid    - per-entry valid bits
//   waddr    - per-entry word addresses
//   data     - per-entry data words
//   tail     - next write slot; the youngest entry sits at tail-1
//   ld_waddr - probe word address
//   hit      - some valid entry matches
//   hit_data - youngest matching data, 0 when hit=0
module sb_fwd_match
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = cpu_pkg::XLEN,
    localparam int AW    = XLEN - WORD_OFF_W,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]           valid,
    input  logic [DEPTH-1:0][AW-1:0]   waddr,
    input  logic [DEPTH-1:0][XLEN-1:0] data,
    input  logic [PW-1:0]              tail,
    input  logic [AW-1:0]              ld_waddr,
    output logic                       hit,
    output logic [XLEN-1:0]            hit_data
);

    // Walk from oldest (tail-DEPTH == tail) to youngest (tail-1); a later
    // match overwrites an earlier one, so the youngest match wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        hit      = 1'b0;
        hit_data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid[tail - PW'(k)] && waddr[tail - PW'(k)] == ld_waddr) begin
                hit      = 1'b1;
                hit_data = data[tail - PW'(k)];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order circular store buffer between the pipeline and data
// memory, with store-to-load forwarding.
//   clk, rst                  - clock, synchronous active-high reset
//   st_valid/st_ready         - store handshake from the pipeline
//   st_addr/st_data           - store byte address (bits [1:0] ignored), data
//   mem_write/mem_ready       - head-entry handshake to data memory
//   mem_addr/mem_data         - head word address (bits [1:0]=0) and data
//   ld_addr                   - load probe byte address
//   ld_hit/ld_data            - forwarding result (youngest match, else 0)
//   count/empty               - occupancy
module store_buffer
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = cpu_pkg::XLEN,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    output logic            mem_write,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_hit,
    output logic [XLEN-1:0] ld_data,
    output logic [CW-1:0]   count,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int AW = XLEN - WORD_OFF_W;

    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [DEPTH-1:0]           valid;
    logic [DEPTH-1:0][AW-1:0]   addr_mem;
    logic [DEPTH-1:0][XLEN-1:0] data_mem;

    logic enq;
    logic ret;

    // Byte offsets are meaningless for word stores and word-granular matching.
    logic unused_offsets;
    assign unused_offsets = ^{st_addr[WORD_OFF_W-1:0], ld_addr[WORD_OFF_W-1:0]};

    // Handshake status comes from registered count only, so there is no
    // combinational path from st_* or mem_ready into st_ready or mem_*.
    assign empty     = (count == '0);
    assign st_ready  = (count != CW'(DEPTH));
    assign mem_write = !empty;
    assign enq       = st_valid && st_ready;
    assign ret       = mem_write && mem_ready;

    // Head payload is masked while empty so stale slots never reach memory
    // and the outputs read 0 straight out of reset.
    assign mem_addr = empty ? '0 : {addr_mem[head], {WORD_OFF_W{1'b0}}};
    assign mem_data = empty ? '0 : data_mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based
            // on pre-edge values, so enqueue and retire compose correctly.
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            // A retire never targets the enqueue slot: enqueue needs not-full,
            // retire needs not-empty, so head != tail when both happen.
            if (ret) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            count <= count + CW'(enq) - CW'(ret);
        end
    end

    // NOTE: the payload array has no reset; valid bits and count gate every
    // use of it, and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= st_addr[XLEN-1:WORD_OFF_W];
            data_mem[tail] <= st_data;
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fwd (
        .valid    (valid),
        .waddr    (addr_mem),
        .data     (data_mem),
        .tail     (tail),
        .ld_waddr (ld_addr[XLEN-1:WORD_OFF_W]),
        .hit      (ld_hit),
        .hit_data (ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer. A queue-based model
// (oldest entry at the front) predicts every output each cycle; directed
// scenarios add explicit constant checks, then random traffic runs.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            st_valid;
    logic            st_ready;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_data;
    logic            mem_write;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] ld_addr;
    logic            ld_hit;
    logic [XLEN-1:0] ld_data;
    logic [CW-1:0]   count;
    logic            empty;

    store_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_write (mem_write),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:2] wa;
        logic [XLEN-1:0] d;
    } ent_t;

    ent_t            q[$];        // model contents, oldest first
    logic [XLEN-1:0] retired[$];  // addresses the DUT retired, in order

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs just after a rising edge, compare all
    // outputs against the model at the falling edge, then advance the model
    // across the next rising edge.
    task automatic cycle(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d,
                         input logic mr, input logic [XLEN-1:0] la, input logic r);
        bit              enq;
        bit              ret;
        bit              exp_hit;
        logic [XLEN-1:0] exp_ld;
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        mem_ready = mr;
        ld_addr   = la;
        rst       = r;
        #4;
        exp_hit = 1'b0;
        exp_ld  = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].wa == la[XLEN-1:2]) begin
                exp_hit = 1'b1;
                exp_ld  = q[i].d;
                break;
            end
        end
        check("st_ready",  XLEN'(st_ready),  XLEN'(q.size() != DEPTH));
        check("empty",     XLEN'(empty),     XLEN'(q.size() == 0));
        check("count",     XLEN'(count),     XLEN'(q.size()));
        check("mem_write", XLEN'(mem_write), XLEN'(q.size() != 0));
        check("mem_addr",  mem_addr, (q.size() != 0) ? {q[0].wa, 2'b00} : '0);
        check("mem_data",  mem_data, (q.size() != 0) ? q[0].d : '0);
        check("ld_hit",    XLEN'(ld_hit),    XLEN'(exp_hit));
        check("ld_data",   ld_data, exp_ld);
        if (!r && mem_write && mem_ready) retired.push_back(mem_addr);
        enq = !r && v && (q.size() != DEPTH);
        ret = !r && mr && (q.size() != 0);
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (ret) void'(q.pop_front());
            if (enq) q.push_back('{a[XLEN-1:2], d});
        end
        #1;
    endtask

    task automatic store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic mr);
        cycle(1'b1, a, d, mr, '0, 1'b0);
    endtask

    task automatic idle(input logic mr);
        cycle(1'b0, '0, '0, mr, '0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        mem_ready = 1'b0;
        ld_addr   = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        // Reset state
        check("rst_st_ready",  XLEN'(st_ready),  32'd1);
        check("rst_mem_write", XLEN'(mem_write), 32'd0);
        check("rst_mem_addr",  mem_addr,         32'd0);
        check("rst_mem_data",  mem_data,         32'd0);
        check("rst_ld_hit",    XLEN'(ld_hit),    32'd0);
        check("rst_ld_data",   ld_data,          32'd0);
        check("rst_count",     XLEN'(count),     32'd0);
        check("rst_empty",     XLEN'(empty),     32'd1);
        @(posedge clk);
        #1;

        // Single store, one-cycle latency, held until accepted
        store(32'h10, 32'hDEADBEEF, 1'b0);
        check("lat_mem_write", XLEN'(mem_write), 32'd1);
        idle(1'b0);
        check("hold_mem_addr", mem_addr, 32'h10);
        check("hold_mem_data", mem_data, 32'hDEADBEEF);
        idle(1'b1);
        check("drain_empty", XLEN'(empty), 32'd1);

        // Fill to full, retire while full, then drain in order
        retired.delete();
        for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
        check("full_count",    XLEN'(count),    32'd4);
        check("full_st_ready", XLEN'(st_ready), 32'd0);
        store(32'h50, 32'h104, 1'b1);
        check("full_retire_count", XLEN'(count), 32'd3);
        store(32'h50, 32'h104, 1'b0);
        check("refill_count", XLEN'(count), 32'd4);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("order_n", XLEN'(retired.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < retired.size()) check("order_addr", retired[i], 32'h40 + 32'(4 * i));
        end

        // Forwarding, youngest match wins
        store(32'h20, 32'h1, 1'b0);
        store(32'h24, 32'h2, 1'b0);
        store(32'h20, 32'h3, 1'b0);
        ld_addr = 32'h22;
        #1;
        check("fwd_hit",  XLEN'(ld_hit), 32'd1);
        check("fwd_data", ld_data,       32'h3);
        ld_addr = 32'h28;
        #1;
        check("fwd_miss_hit",  XLEN'(ld_hit), 32'd0);
        check("fwd_miss_data", ld_data,       32'h0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Steady-state streaming with pointer wrap
        retired.delete();
        store(32'h60, 32'hA0, 1'b0);
        store(32'h64, 32'hA1, 1'b0);
        for (int i = 0; i < 8; i++) store(32'h68 + 32'(4 * i), 32'hA2 + 32'(i), 1'b1);
        check("stream_count", XLEN'(count), 32'd2);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("stream_n", XLEN'(retired.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < retired.size()) check("stream_order", retired[i], 32'h60 + 32'(4 * i));
        end

        // Reset with stores pending discards them
        for (int i = 0; i < 3; i++) store(32'h80 + 32'(4 * i), 32'(i), 1'b0);
        cycle(1'b0, '0, '0, 1'b1, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("post_rst_mem_write", XLEN'(mem_write), 32'd0);
        end
        check("post_rst_empty",    XLEN'(empty),    32'd1);
        check("post_rst_st_ready", XLEN'(st_ready), 32'd1);

        // Random traffic over a small address pool to force matches
        for (int n = 0; n < 600; n++) begin
            logic [XLEN-1:0] a;
            logic [XLEN-1:0] la;
            a  = 32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            la = 32'h100 + 32'($urandom_range(0, 8) << 2) + 32'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), a, $urandom(), 1'($urandom_range(0, 2) == 0),
                  la, 1'($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
